int_mul_pipe: RTL and testbench

INT_MUL_PIPE -- requirements
Module: int_mul_pipe

---
 rtl/mul_pkg.sv | 43 ++++
 rtl/int_mul_pipe_if.sv | 32 +++
 rtl/mul_operand_prep.sv | 26 ++
 rtl/int_mul_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_int_mul_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined integer multiplier: func3 encodings,
// parameter defaults, stage payload layout and an operation legality helper.
package mul_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int STAGES_DEF = 3;
    localparam int TAG_W_DEF  = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // Control portion of every stage register, independent of XLEN/TAG_W.
    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [2:0] func3;
        logic       int_32;
    } mul_ctrl_t;

    // Full stage payload in the default configuration.
    typedef struct packed {
        logic                    valid;
        logic [TAG_W_DEF-1:0]    tag;
        logic                    sign;
        logic [2:0]              func3;
        logic                    int_32;
        logic [2*XLEN_DEF-1:0]   product;
    } mul_payload_t;

    // Reserved func3 codes and word forms of the high-half ops yield zero.
    function automatic logic op_is_legal(input logic [2:0] func3, input logic int_32);
        logic legal;
        case (func3)
            F3_MUL:                       legal = 1'b1;
            F3_MULH, F3_MULHSU, F3_MULHU: legal = ~int_32;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/int_mul_pipe_if.sv
// Request/response bundle of the multiplier. Port names keep their
// direction suffixes as seen from the multiplier.
interface int_mul_pipe_if
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic             valid_i;
    logic [2:0]       func3_i;
    logic             int_32_i;
    logic [TAG_W-1:0] tag_i;
    logic [XLEN-1:0]  src1_i;
    logic [XLEN-1:0]  src2_i;
    logic             kill_i;
    logic             stall_i;
    logic             ready_o;
    logic             valid_o;
    logic [TAG_W-1:0] tag_o;
    logic [XLEN-1:0]  result_o;
    logic             busy_o;

    modport master (
        output valid_i, func3_i, int_32_i, tag_i, src1_i, src2_i, kill_i, stall_i,
        input  ready_o, valid_o, tag_o, result_o, busy_o
    );

    modport slave (
        input  valid_i, func3_i, int_32_i, tag_i, src1_i, src2_i, kill_i, stall_i,
        output ready_o, valid_o, tag_o, result_o, busy_o
    );
endinterface

// File: rtl/mul_operand_prep.sv
// Converts one operand into an unsigned magnitude plus a negative flag.
// An XLEN-bit unsigned magnitude holds 2^(XLEN-1) exactly, so the most
// negative input needs no extra bit.
module mul_operand_prep #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] src,
    input  logic            is_signed,
    input  logic            word,
    output logic [XLEN-1:0] mag,
    output logic            neg
);
    logic [XLEN-1:0] ext_s;

    // Word ops only look at the low 32 bits, sign-extended to XLEN
    always_comb begin
        ext_s = '0;
        for (int i = 0; i < XLEN; i++) begin
            ext_s[i] = (word && (i >= 32)) ? src[31] : src[i];
        end
    end

    assign neg = is_signed & ext_s[XLEN-1];
    assign mag = neg ? (~ext_s + {{(XLEN-1){1'b0}}, 1'b1}) : ext_s;

endmodule

// File: rtl/int_mul_pipe.sv
// Fully pipelined RISC-V M-extension multiplier. Stage 1 forms magnitudes
// and two partial products, the middle stage(s) sum them, and the final
// stage restores the sign and selects the requested half.
module int_mul_pipe
    import mul_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic            clk_i,
    input logic            rst_ni,
    int_mul_pipe_if.slave  bus
);
    localparam int HALF = XLEN / 2;
    localparam int PPW  = XLEN + HALF;
    localparam int PW   = 2 * XLEN;

    logic             advance_s;
    logic             accept_s;
    logic             word_s;
    logic             a_signed_s;
    logic             b_signed_s;
    logic [XLEN-1:0]  mag_a_s;
    logic [XLEN-1:0]  mag_b_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [PPW-1:0]   pp_lo_s;
    logic [PPW-1:0]   pp_hi_s;

    mul_ctrl_t        s1_ctrl_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic [PPW-1:0]   s1_lo_r;
    logic [PPW-1:0]   s1_hi_r;

    mul_ctrl_t        prod_ctrl_s;
    logic [TAG_W-1:0] prod_tag_s;
    logic [PW-1:0]    prod_val_s;
    logic             mid_busy_s;

    logic [PW-1:0]    signed_prod_s;
    logic [XLEN-1:0]  result_s;
    logic             out_valid_r;
    logic [TAG_W-1:0] out_tag_r;
    logic [XLEN-1:0]  out_result_r;

    assign advance_s   = ~bus.stall_i;
    assign accept_s    = bus.valid_i & ~bus.stall_i & ~bus.kill_i;
    assign bus.ready_o = ~bus.stall_i;

    // Decode operand signedness and whether this is a word operation
    always_comb begin
        word_s = bus.int_32_i & (bus.func3_i == F3_MUL);
        case (bus.func3_i)
            F3_MUL, F3_MULH: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            F3_MULHSU:       begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            default:         begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end

    mul_operand_prep #(.XLEN(XLEN)) u_prep_a (
        .src(bus.src1_i), .is_signed(a_signed_s), .word(word_s), .mag(mag_a_s), .neg(neg_a_s)
    );
    mul_operand_prep #(.XLEN(XLEN)) u_prep_b (
        .src(bus.src2_i), .is_signed(b_signed_s), .word(word_s), .mag(mag_b_s), .neg(neg_b_s)
    );

    assign pp_lo_s = {{HALF{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s[HALF-1:0]};
    assign pp_hi_s = {{HALF{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s[XLEN-1:HALF]};

    // Stage 1: capture sign flag, op info and partial products
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_ctrl_r <= '0;
            s1_tag_r  <= '0;
            s1_lo_r   <= '0;
            s1_hi_r   <= '0;
        end else if (bus.kill_i) begin
            s1_ctrl_r.valid <= 1'b0;
        end else if (advance_s) begin
            s1_ctrl_r.valid  <= accept_s;
            s1_ctrl_r.sign   <= neg_a_s ^ neg_b_s;
            s1_ctrl_r.func3  <= bus.func3_i;
            s1_ctrl_r.int_32 <= bus.int_32_i;
            s1_tag_r         <= bus.tag_i;
            s1_lo_r          <= pp_lo_s;
            s1_hi_r          <= pp_hi_s;
        end
    end

    generate
        if (STAGES == 4) begin : g_mid4
            mul_ctrl_t        s2_ctrl_r;
            mul_ctrl_t        s3_ctrl_r;
            logic [TAG_W-1:0] s2_tag_r;
            logic [TAG_W-1:0] s3_tag_r;
            logic [XLEN:0]    s2_low_r;
            logic [HALF-1:0]  s2_lo_top_r;
            logic [XLEN-1:0]  s2_hi_top_r;
            logic [PW-1:0]    s3_prod_r;
            logic [XLEN:0]    low_sum_s;
            logic [XLEN-1:0]  upper_s;

            assign low_sum_s = {1'b0, s1_lo_r[XLEN-1:0]} + {1'b0, s1_hi_r[HALF-1:0], {HALF{1'b0}}};
            assign upper_s   = s2_hi_top_r + {{(XLEN-HALF){1'b0}}, s2_lo_top_r}
                             + {{(XLEN-1){1'b0}}, s2_low_r[XLEN]};

            // Stages 2-3: low half of the sum with carry, then the upper half
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s2_ctrl_r   <= '0;
                    s3_ctrl_r   <= '0;
                    s2_tag_r    <= '0;
                    s3_tag_r    <= '0;
                    s2_low_r    <= '0;
                    s2_lo_top_r <= '0;
                    s2_hi_top_r <= '0;
                    s3_prod_r   <= '0;
                end else if (bus.kill_i) begin
                    s2_ctrl_r.valid <= 1'b0;
                    s3_ctrl_r.valid <= 1'b0;
                end else if (advance_s) begin
                    s2_ctrl_r   <= s1_ctrl_r;
                    s2_tag_r    <= s1_tag_r;
                    s2_low_r    <= low_sum_s;
                    s2_lo_top_r <= s1_lo_r[PPW-1:XLEN];
                    s2_hi_top_r <= s1_hi_r[PPW-1:HALF];
                    s3_ctrl_r   <= s2_ctrl_r;
                    s3_tag_r    <= s2_tag_r;
                    s3_prod_r   <= {upper_s, s2_low_r[XLEN-1:0]};
                end
            end

            assign prod_ctrl_s = s3_ctrl_r;
            assign prod_tag_s  = s3_tag_r;
            assign prod_val_s  = s3_prod_r;
            assign mid_busy_s  = s2_ctrl_r.valid | s3_ctrl_r.valid;
        end else if (STAGES == 3) begin : g_mid3
            mul_ctrl_t        s2_ctrl_r;
            logic [TAG_W-1:0] s2_tag_r;
            logic [PW-1:0]    s2_prod_r;
            logic [PW-1:0]    sum_s;

            assign sum_s = {{HALF{1'b0}}, s1_lo_r} + {s1_hi_r, {HALF{1'b0}}};

            // Stage 2: full-width product from the shifted partial products
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s2_ctrl_r <= '0;
                    s2_tag_r  <= '0;
                    s2_prod_r <= '0;
                end else if (bus.kill_i) begin
                    s2_ctrl_r.valid <= 1'b0;
                end else if (advance_s) begin
                    s2_ctrl_r <= s1_ctrl_r;
                    s2_tag_r  <= s1_tag_r;
                    s2_prod_r <= sum_s;
                end
            end

            assign prod_ctrl_s = s2_ctrl_r;
            assign prod_tag_s  = s2_tag_r;
            assign prod_val_s  = s2_prod_r;
            assign mid_busy_s  = s2_ctrl_r.valid;
        end else begin : g_mid2
            assign prod_ctrl_s = s1_ctrl_r;
            assign prod_tag_s  = s1_tag_r;
            assign prod_val_s  = {{HALF{1'b0}}, s1_lo_r} + {s1_hi_r, {HALF{1'b0}}};
            assign mid_busy_s  = 1'b0;
        end
    endgenerate

    // Restore the sign of the full product and select the requested half
    always_comb begin
        result_s = '0;
        if (prod_ctrl_s.sign) begin
            signed_prod_s = ~prod_val_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            signed_prod_s = prod_val_s;
        end
        if (!op_is_legal(prod_ctrl_s.func3, prod_ctrl_s.int_32)) begin
            result_s = '0;
        end else if (prod_ctrl_s.func3 == F3_MUL) begin
            for (int i = 0; i < XLEN; i++) begin
                result_s[i] = (prod_ctrl_s.int_32 && (i >= 32)) ? signed_prod_s[31] : signed_prod_s[i];
            end
        end else begin
            result_s = signed_prod_s[PW-1:XLEN];
        end
    end

    // Output stage: registered result, forced to zero when not valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r  <= 1'b0;
            out_tag_r    <= '0;
            out_result_r <= '0;
        end else if (bus.kill_i) begin
            out_valid_r  <= 1'b0;
            out_tag_r    <= '0;
            out_result_r <= '0;
        end else if (advance_s) begin
            out_valid_r  <= prod_ctrl_s.valid;
            out_tag_r    <= prod_ctrl_s.valid ? prod_tag_s : '0;
            out_result_r <= prod_ctrl_s.valid ? result_s : '0;
        end
    end

    assign bus.valid_o  = out_valid_r;
    assign bus.tag_o    = out_tag_r;
    assign bus.result_o = out_result_r;
    assign bus.busy_o   = s1_ctrl_r.valid | mid_busy_s | out_valid_r;

endmodule

// File: tb/tb_int_mul_pipe.sv
// Self-checking bench for int_mul_pipe (XLEN=64, STAGES=3, TAG_W=5).
// Reference: plain 128-bit arithmetic plus a queue of accepted operations
// indexed by the number of non-stalled clock edges.
module tb_int_mul_pipe;
    localparam int XLEN   = 64;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    logic clk = 1'b0;
    logic rst_n;

    int_mul_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    int_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               acc;
        logic [TAG_W-1:0] tag;
        logic [63:0]      res;
    } exp_t;

    exp_t             model_q[$];
    int               adv_cnt;
    int               n_checks;
    int               n_fail;
    logic             exp_valid;
    logic             exp_busy;
    logic [TAG_W-1:0] exp_tag;
    logic [63:0]      exp_result;

    function automatic logic [63:0] ref_mul(input logic [2:0] f, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, p;
        logic [63:0] r;
        r = 64'h0;
        p = 128'h0;
        if (w && f != 3'b000) begin
            r = 64'h0;
        end else if (w) begin
            sa = {{96{a[31]}}, a[31:0]};
            sb = {{96{b[31]}}, b[31:0]};
            p  = sa * sb;
            r  = {{32{p[31]}}, p[31:0]};
        end else begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            case (f)
                3'b000: begin p = sa * sb; r = p[63:0]; end
                3'b001: begin p = sa * sb; r = p[127:64]; end
                3'b010: begin sb = {64'h0, b}; p = sa * sb; r = p[127:64]; end
                3'b011: begin sa = {64'h0, a}; sb = {64'h0, b}; p = sa * sb; r = p[127:64]; end
                default: r = 64'h0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'h8000_0000_0000_0000;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h0000_0000_8000_0000;
            3:       v = {32'h0, $urandom()};
            4:       v = 64'h0;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    task automatic drive(input logic v, input logic [2:0] f, input logic w,
                         input logic [TAG_W-1:0] t, input logic [63:0] a, input logic [63:0] b);
        bus.valid_i  = v;
        bus.func3_i  = f;
        bus.int_32_i = w;
        bus.tag_i    = t;
        bus.src1_i   = a;
        bus.src2_i   = b;
    endtask

    // One clock edge: update the reference queue, then derive expectations.
    task automatic step();
        @(posedge clk);
        if (!rst_n || bus.kill_i) begin
            model_q.delete();
        end else if (!bus.stall_i) begin
            adv_cnt++;
            if (bus.valid_i) begin
                model_q.push_back('{adv_cnt, bus.tag_i,
                    ref_mul(bus.func3_i, bus.int_32_i, bus.src1_i, bus.src2_i)});
            end
        end
        #1;
        while (model_q.size() > 0 && model_q[0].acc + STAGES - 1 < adv_cnt) begin
            void'(model_q.pop_front());
        end
        exp_busy  = (model_q.size() > 0);
        exp_valid = 1'b0;
        exp_tag   = '0;
        exp_result = 64'h0;
        if (exp_busy && (model_q[0].acc + STAGES - 1 == adv_cnt)) begin
            exp_valid  = 1'b1;
            exp_tag    = model_q[0].tag;
            exp_result = model_q[0].res;
        end
    endtask

    task automatic drain();
        drive(1'b0, 3'b000, 1'b0, '0, 64'h0, 64'h0);
        bus.stall_i = 1'b0;
        bus.kill_i  = 1'b0;
        repeat (STAGES + 1) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 1'b0, '0, 64'h0, 64'h0);
        bus.kill_i  = 1'b0;
        bus.stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            bus.stall_i = (s == 1);
            #1;
            n_checks++;
            if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'h0 || bus.tag_o !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: valid=%b busy=%b result=%h tag=%h, required 0 0 0 0",
                         bus.valid_o, bus.busy_o, bus.result_o, bus.tag_o);
            end
            n_checks++;
            if (bus.ready_o !== (s == 0)) begin
                n_fail++;
                $display("FAIL reset_ready: ready=%b, required %b", bus.ready_o, (s == 0));
            end
        end
        bus.stall_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
    endtask

    task automatic test_directed();
        logic [2:0]  vf [8];
        logic        vw [8];
        logic [63:0] va [8];
        logic [63:0] vb [8];
        logic [63:0] vr [8];
        vf = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b101, 3'b001, 3'b000};
        vw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        va = '{64'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_7FFF_FFFF, 64'd9, 64'd3, 64'h8000_0000_0000_0000};
        vb = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd2, 64'd9, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
        vr = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0, 64'h8000_0000_0000_0000};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vf[i], vw[i], TAG_W'(i + 5), va[i], vb[i]);
            step();
            drive(1'b0, 3'b000, 1'b0, '0, 64'h0, 64'h0);
            n_checks++;
            if (bus.valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_early_1 op%0d: valid=%b, required 0", i, bus.valid_o);
            end
            step();
            n_checks++;
            if (bus.valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_early_2 op%0d: valid=%b, required 0", i, bus.valid_o);
            end
            step();
            n_checks++;
            if (bus.valid_o !== 1'b1 || bus.tag_o !== TAG_W'(i + 5) || bus.result_o !== vr[i]) begin
                n_fail++;
                $display("FAIL directed_result op%0d: valid=%b tag=%0d result=%h, required 1 %0d %h",
                         i, bus.valid_o, bus.tag_o, bus.result_o, i + 5, vr[i]);
            end
            step();
            n_checks++;
            if (bus.valid_o !== 1'b0 || bus.result_o !== 64'h0 || bus.tag_o !== '0) begin
                n_fail++;
                $display("FAIL directed_idle op%0d: valid=%b tag=%0d result=%h, required 0 0 0",
                         i, bus.valid_o, bus.tag_o, bus.result_o);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] f;
        for (int c = 0; c < 400; c++) begin
            f = ($urandom_range(0, 5) < 4) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 3) != 0), f, ($urandom_range(0, 3) == 0),
                  TAG_W'($urandom()), rand_operand(), rand_operand());
            bus.stall_i = ($urandom_range(0, 4) == 0);
            bus.kill_i  = ($urandom_range(0, 39) == 0);
            step();
            n_checks++;
            if (bus.valid_o !== exp_valid || bus.tag_o !== exp_tag || bus.result_o !== exp_result) begin
                n_fail++;
                $display("FAIL random_out c%0d: valid=%b tag=%0d result=%h, required %b %0d %h",
                         c, bus.valid_o, bus.tag_o, bus.result_o, exp_valid, exp_tag, exp_result);
            end
            n_checks++;
            if (bus.busy_o !== exp_busy) begin
                n_fail++;
                $display("FAIL random_busy c%0d: busy=%b, required %b", c, bus.busy_o, exp_busy);
            end
            n_checks++;
            if (bus.ready_o !== ~bus.stall_i) begin
                n_fail++;
                $display("FAIL random_ready c%0d: ready=%b, required %b", c, bus.ready_o, ~bus.stall_i);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] oa [4];
        logic [63:0] ob [4];
        logic [2:0]  of [4];
        int          in_op [9];
        int          st    [9];
        int          out_op [9];
        in_op  = '{0, 1, 2, 3, 3, 3, -1, -1, -1};
        st     = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
        out_op = '{-1, -1, 0, 0, 0, 1, 2, 3, -1};
        for (int k = 0; k < 4; k++) begin
            oa[k] = rand_operand();
            ob[k] = rand_operand();
            of[k] = 3'($urandom_range(0, 3));
        end
        for (int t = 0; t < 9; t++) begin
            if (in_op[t] >= 0) begin
                drive(1'b1, of[in_op[t]], 1'b0, TAG_W'(10 + in_op[t]), oa[in_op[t]], ob[in_op[t]]);
            end else begin
                drive(1'b0, 3'b000, 1'b0, '0, 64'h0, 64'h0);
            end
            bus.stall_i = (st[t] == 1);
            step();
            if (out_op[t] >= 0) begin
                n_checks++;
                if (bus.valid_o !== 1'b1 || bus.tag_o !== TAG_W'(10 + out_op[t]) ||
                    bus.result_o !== ref_mul(of[out_op[t]], 1'b0, oa[out_op[t]], ob[out_op[t]])) begin
                    n_fail++;
                    $display("FAIL b2b_result step%0d: valid=%b tag=%0d result=%h, required 1 %0d %h",
                             t + 1, bus.valid_o, bus.tag_o, bus.result_o, 10 + out_op[t],
                             ref_mul(of[out_op[t]], 1'b0, oa[out_op[t]], ob[out_op[t]]));
                end
            end else begin
                n_checks++;
                if (bus.valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle step%0d: valid=%b, required 0", t + 1, bus.valid_o);
                end
            end
        end
        drain();
    endtask

    task automatic test_kill();
        int kv [11];
        int kk [11];
        int ks [11];
        int kb [11];
        kv = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        kk = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        ks = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        kb = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int t = 0; t < 11; t++) begin
            drive((kv[t] == 1), 3'b000, 1'b0, TAG_W'(20 + t), rand_operand(), rand_operand());
            bus.kill_i  = (kk[t] == 1);
            bus.stall_i = (ks[t] == 1);
            step();
            n_checks++;
            if (bus.valid_o !== 1'b0 || bus.busy_o !== (kb[t] == 1)) begin
                n_fail++;
                $display("FAIL kill_flush step%0d: valid=%b busy=%b, required 0 %b",
                         t + 1, bus.valid_o, bus.busy_o, (kb[t] == 1));
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [63:0] a;
        logic [63:0] b;
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 3'b000, 1'b0, TAG_W'(t + 1), 64'd3, 64'(t + 4));
            step();
        end
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.tag_o !== 5'd1 || bus.result_o !== 64'd12) begin
            n_fail++;
            $display("FAIL areset_pre: valid=%b tag=%0d result=%h, required 1 1 c",
                     bus.valid_o, bus.tag_o, bus.result_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'h0 || bus.tag_o !== '0) begin
            n_fail++;
            $display("FAIL areset_drop: valid=%b busy=%b result=%h tag=%0d, required 0 0 0 0",
                     bus.valid_o, bus.busy_o, bus.result_o, bus.tag_o);
        end
        model_q.delete();
        drive(1'b0, 3'b000, 1'b0, '0, 64'h0, 64'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            n_checks++;
            if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_stale step%0d: valid=%b busy=%b, required 0 0",
                         t + 1, bus.valid_o, bus.busy_o);
            end
        end
        a = rand_operand();
        b = rand_operand();
        drive(1'b1, 3'b001, 1'b0, 5'd30, a, b);
        step();
        drive(1'b0, 3'b000, 1'b0, '0, 64'h0, 64'h0);
        step();
        step();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.tag_o !== 5'd30 || bus.result_o !== ref_mul(3'b001, 1'b0, a, b)) begin
            n_fail++;
            $display("FAIL areset_resume: valid=%b tag=%0d result=%h, required 1 30 %h",
                     bus.valid_o, bus.tag_o, bus.result_o, ref_mul(3'b001, 1'b0, a, b));
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        adv_cnt  = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_kill();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
